// File: rtl/serial_dump_pkg.sv
// Shared constants and state encoding for the PSRAM-to-UART hex dumper.
package serial_dump_pkg;

  localparam logic [2:0] SD_REG_ADDR = 3'b001;
  localparam logic [2:0] SD_REG_CNT  = 3'b010;
  localparam logic [2:0] SD_REG_GO   = 3'b011;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_A     = 8'h61;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_TX,
    ST_TXW,
    ST_SPACE,
    ST_DONE
  } sd_state_e;

  // Control-port values arrive little-endian byte order; registers hold them swapped.
  function automatic logic [31:0] byte_swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/serial_dump_hex.sv
// Converts one 4-bit nibble into its lowercase ASCII hex character.
module hex_nibble_to_ascii
  import serial_dump_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  // Digits map onto '0'..'9', values ten and above onto 'a'..'f'.
  always_comb begin
    if (nib_i < 4'd10) asc_o = CHAR_0 + {4'd0, nib_i};
    else               asc_o = CHAR_A + {4'd0, nib_i} - 8'd10;
  end

endmodule

// File: rtl/serial_dump.sv
// Reads a block of PSRAM words and sends them over the UART as lowercase hex,
// most significant nibble first, followed by a single space. The memory port is
// taken over from the CPU for the whole dump.
module serial_dump
  import serial_dump_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic        ready,
  input  logic        burst_en_cpu,
  input  logic [7:0]  burst_length_cpu,
  input  logic [31:0] a_cpu,
  input  logic [31:0] d_cpu,
  input  logic        we_cpu,
  input  logic        rd_cpu,
  output logic [31:0] spo_cpu,
  output logic        ready_cpu,
  output logic        burst_en_mem,
  output logic [7:0]  burst_length_mem,
  output logic [31:0] a_mem,
  output logic [31:0] d_mem,
  output logic        we_mem,
  output logic        rd_mem,
  input  logic [31:0] spo_mem,
  input  logic        ready_mem,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_we,
  input  logic        uart_tx_ready
);

  sd_state_e        state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;
  logic [2:0]       nib_q, nib_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_we_q, tx_we_d;
  logic             rd_fsm;
  logic             override;
  logic [3:0]       nib_sel;
  logic [7:0]       nib_asc;

  assign nib_sel = word_q[{nib_q, 2'b00} +: 4];

  hex_nibble_to_ascii u_hex (
    .nib_i (nib_sel),
    .asc_o (nib_asc)
  );

  // Next-state logic: register writes in IDLE, then read/emit/advance per word.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    nib_d     = nib_q;
    tx_data_d = tx_data_q;
    tx_we_d   = 1'b0;
    rd_fsm    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (we) begin
          case (a)
            SD_REG_ADDR: addr_d = byte_swap(d);
            SD_REG_CNT:  cnt_d  = CNT_W'(byte_swap(d));
            SD_REG_GO:   state_d = (cnt_q == '0) ? ST_SPACE : ST_RD;
            default:     ;
          endcase
        end
      end
      ST_RD: begin
        rd_fsm = 1'b1;
        if (ready_mem) begin
          word_d  = spo_mem;
          nib_d   = 3'd7;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        if (uart_tx_ready) begin
          tx_we_d   = 1'b1;
          tx_data_d = nib_asc;
          state_d   = ST_TXW;
        end
      end
      ST_TXW: begin
        // Strobe is visible this cycle; give the transmitter time to drop ready.
        if (nib_q != 3'd0) begin
          nib_d   = nib_q - 3'd1;
          state_d = ST_TX;
        end else begin
          addr_d  = addr_q + 32'd4;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? ST_SPACE : ST_RD;
        end
      end
      ST_SPACE: begin
        if (uart_tx_ready) begin
          tx_we_d   = 1'b1;
          tx_data_d = CHAR_SPACE;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and UART outputs; a reset mid-dump abandons it silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_we_q   <= tx_we_d;
    end
  end

  // Word buffer and nibble index are always written before use.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    nib_q  <= nib_d;
  end

  assign override     = (state_q != ST_IDLE);
  assign ready        = ~override;
  assign uart_tx_data = tx_data_q;
  assign uart_tx_we   = tx_we_q;

  assign spo_cpu   = spo_mem;
  assign ready_cpu = ready_mem;

  assign burst_en_mem     = override ? 1'b0  : burst_en_cpu;
  assign burst_length_mem = override ? 8'd0  : burst_length_cpu;
  assign a_mem            = override ? {2'b00, addr_q[31:2]} : a_cpu;
  assign d_mem            = override ? 32'd0 : d_cpu;
  assign we_mem           = override ? 1'b0  : we_cpu;
  assign rd_mem           = override ? rd_fsm : rd_cpu;

endmodule

// File: tb/tb_serial_dump.sv
// Randomized scoreboard bench for serial_dump with memory and UART models.
module tb_serial_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  a = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0;
  logic        ready;
  logic        burst_en_cpu = 1'b0;
  logic [7:0]  burst_length_cpu = '0;
  logic [31:0] a_cpu = '0;
  logic [31:0] d_cpu = '0;
  logic        we_cpu = 1'b0;
  logic        rd_cpu = 1'b0;
  logic [31:0] spo_cpu;
  logic        ready_cpu;
  logic        burst_en_mem;
  logic [7:0]  burst_length_mem;
  logic [31:0] a_mem;
  logic [31:0] d_mem;
  logic        we_mem;
  logic        rd_mem;
  logic [31:0] spo_mem = '0;
  logic        ready_mem = 1'b0;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_we;
  logic        uart_tx_ready = 1'b1;

  always #5 clk = ~clk;

  serial_dump #(.CNT_W(24)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .ready(ready),
    .burst_en_cpu(burst_en_cpu), .burst_length_cpu(burst_length_cpu),
    .a_cpu(a_cpu), .d_cpu(d_cpu), .we_cpu(we_cpu), .rd_cpu(rd_cpu),
    .spo_cpu(spo_cpu), .ready_cpu(ready_cpu),
    .burst_en_mem(burst_en_mem), .burst_length_mem(burst_length_mem),
    .a_mem(a_mem), .d_mem(d_mem), .we_mem(we_mem), .rd_mem(rd_mem),
    .spo_mem(spo_mem), .ready_mem(ready_mem),
    .uart_tx_data(uart_tx_data), .uart_tx_we(uart_tx_we), .uart_tx_ready(uart_tx_ready)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] fixed_w [2];
  int mem_delay = 0;
  int stall_len = 0;
  int strobe_cnt = 0;
  int rd_events = 0;

  // model-private state
  int   scnt = 0;
  int   wait_cnt = 0;
  int   rd_hi = 0;
  bit   mbusy = 0;
  logic prev_we = 1'b0;
  logic [7:0] last_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Monitor, UART transmitter model and memory model, all sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_we = 1'b0; last_data = 8'h00;
      ready_mem = 1'b0; mbusy = 0; wait_cnt = 0; rd_hi = 0;
      uart_tx_ready = 1'b1; scnt = 0;
    end else begin
      if (uart_tx_we) begin
        chk("strobe_needs_ready", uart_tx_ready, 1'b1);
        chk("strobe_not_back_to_back", prev_we, 1'b0);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_char: got %0h expected none", uart_tx_data);
        end else begin
          chk("char", uart_tx_data, exp_q.pop_front());
        end
        last_data = uart_tx_data;
        strobe_cnt++;
      end else if (!uart_tx_ready) begin
        chk("data_hold_in_stall", uart_tx_data, last_data);
      end
      prev_we = uart_tx_we;

      if (we && a == 3'b011 && ready && stall_len > 0) begin
        uart_tx_ready = 1'b0; scnt = 0;
      end else if (uart_tx_we && stall_len > 0) begin
        uart_tx_ready = 1'b0; scnt = 0;
      end else if (!uart_tx_ready) begin
        scnt++;
        if (scnt >= stall_len) uart_tx_ready = 1'b1;
      end

      if (ready_mem) begin
        ready_mem = 1'b0; mbusy = 0; wait_cnt = 0; rd_hi = 0;
      end else if (rd_mem || mbusy) begin
        mbusy = 1;
        if (rd_mem) rd_hi++;
        if (wait_cnt >= mem_delay) begin
          ready_mem = 1'b1;
          spo_mem = mem.exists(a_mem) ? mem[a_mem] : 32'h0;
          rd_events++;
          chk("rd_mem_held", rd_hi, mem_delay + 1);
          if (!ready) begin
            if (exp_addr_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_read: got %0h expected none", a_mem);
            end else chk("a_mem", a_mem, exp_addr_q.pop_front());
          end
        end else wait_cnt++;
      end
    end
  end

  task automatic wr(input logic [2:0] sel, input logic [31:0] val);
    a = sel; d = val; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic dump(input logic [31:0] base, input int n, input int dly, input int stl,
                      input bit poke, input bit ovr, input bit fixed);
    int s0, r0, budget;
    bit done;
    logic [31:0] w, t;
    string s;
    mem_delay = dly; stall_len = stl;
    for (int i = 0; i < n; i++) begin
      t = base + 32'(4 * i);
      w = fixed ? fixed_w[i] : $urandom;
      mem[t >> 2] = w;
      exp_addr_q.push_back(t >> 2);
      s = $sformatf("%08h", w);
      for (int k = 0; k < 8; k++) exp_q.push_back(s[k]);
    end
    exp_q.push_back(8'h20);
    s0 = strobe_cnt; r0 = rd_events;
    wr(3'b001, bswap(base));
    wr(3'b010, bswap(32'(n)));
    wr(3'b011, $urandom);
    chk("busy_after_go", ready, 1'b0);
    if (ovr) begin
      chk("ovr_we_mem", we_mem, 1'b0);
      chk("ovr_a_mem", a_mem, {2'b00, base[31:2]});
      chk("ovr_burst_en", burst_en_mem, 1'b0);
      chk("ovr_burst_len", burst_length_mem, 8'd0);
      chk("ovr_d_mem", d_mem, 32'd0);
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      wr(3'b001, $urandom);
      wr(3'b010, $urandom);
      wr(3'b011, $urandom);
    end
    budget = (8 * n + 1) * (stl + 6) + n * (dly + 6) + 50;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (ready && exp_q.size() == 0) done = 1;
    end
    chk("dump_completes", done, 1'b1);
    chk("strobe_count", strobe_cnt - s0, 8 * n + 1);
    chk("mem_read_count", rd_events - r0, n);
    chk("ready_after", ready, 1'b1);
    exp_q.delete(); exp_addr_q.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, c;
    logic [31:0] w;
    string s;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_tx_we", uart_tx_we, 1'b0);
    chk("rst_tx_data", uart_tx_data, 8'h00);
    chk("rst_rd_mem", rd_mem, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Fixed two-word dump
    fixed_w[0] = 32'h12345678; fixed_w[1] = 32'hdeadbeef;
    dump(32'h0000_0100, 2, 0, 0, 0, 0, 1);
    // Empty dump: just the space
    dump($urandom, 0, 0, 0, 0, 0, 0);
    // Slow transmitter
    dump($urandom, 1, 0, 50, 0, 0, 0);
    // Slow memory
    dump($urandom, 1, 10, 0, 0, 0, 0);
    // Address wrap
    dump(32'hFFFF_FFFC, 2, 1, 0, 0, 0, 0);

    // CPU traffic during the dump is blocked, restored afterwards
    we_cpu = 1'b1; a_cpu = 32'h200; d_cpu = 32'hcafef00d;
    burst_en_cpu = 1'b1; burst_length_cpu = 8'h05;
    dump(32'h0000_0400, 1, 2, 1, 0, 1, 0);
    chk("pass_a_mem", a_mem, a_cpu);
    chk("pass_we_mem", we_mem, we_cpu);
    chk("pass_d_mem", d_mem, d_cpu);
    chk("pass_burst_en", burst_en_mem, burst_en_cpu);
    chk("pass_burst_len", burst_length_mem, burst_length_cpu);
    chk("pass_rd_mem", rd_mem, rd_cpu);
    chk("pass_spo", spo_cpu, spo_mem);
    chk("pass_ready", ready_cpu, ready_mem);
    we_cpu = 1'b0; a_cpu = '0; d_cpu = '0; burst_en_cpu = 1'b0; burst_length_cpu = '0;

    // Randomized dumps, some with register writes while busy
    for (int r = 0; r < 8; r++)
      dump($urandom, $urandom_range(1, 4), $urandom_range(0, 4), $urandom_range(0, 5),
           $urandom_range(0, 1), 0, 0);

    // Reset in the middle of a dump
    mem_delay = 0; stall_len = 2;
    w = $urandom;
    mem[32'h0000_0040] = w;
    exp_addr_q.push_back(32'h0000_0040);
    s = $sformatf("%08h", w);
    for (int k = 0; k < 8; k++) exp_q.push_back(s[k]);
    s0 = strobe_cnt;
    wr(3'b001, bswap(32'h0000_0100));
    wr(3'b010, bswap(32'd1));
    wr(3'b011, 32'd0);
    c = 0;
    while (strobe_cnt - s0 < 3 && c < 500) begin
      @(negedge clk); c++;
    end
    chk("three_chars_before_reset", strobe_cnt - s0, 3);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx_we", uart_tx_we, 1'b0);
    chk("midrst_ready", ready, 1'b1);
    exp_q.delete(); exp_addr_q.delete();
    #1 rst = 1'b1;
    s0 = strobe_cnt;
    repeat (150) @(negedge clk);
    chk("no_chars_after_reset", strobe_cnt - s0, 0);
    chk("idle_after_reset", ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
